// File: rtl/video_timing_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module  : video_timing_gen
// Brief   : Raster timing generator (blanking, H/V sync, data enable) with a
//           selectable test pattern. Advances only on video clock-enable
//           cycles; all outputs are registered from one counter state so they
//           stay mutually aligned.
// Revision: 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int          H_ACTIVE  = 1920,
    parameter int          H_FP      = 88,
    parameter int          H_SYNC    = 44,
    parameter int          H_BP      = 148,
    parameter int          V_ACTIVE  = 1080,
    parameter int          V_FP      = 4,
    parameter int          V_SYNC    = 5,
    parameter int          V_BP      = 36,
    parameter bit          HS_POL    = 1'b1,
    parameter bit          VS_POL    = 1'b1,
    parameter logic [23:0] SOLID_RGB = 24'hFF_5A_43
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cen_i,
    input  logic [1:0]  pattern_sel_i,
    output logic [23:0] vid_rgb_o,
    output logic [1:0]  vh_blank_o,
    output logic [2:0]  dvh_sync_o,
    output logic        frame_start_o,
    output logic [11:0] h_cnt_o,
    output logic [10:0] v_cnt_o
);

    localparam int          c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [11:0] c_H_LAST   = 12'(c_H_TOTAL - 1);
    localparam logic [10:0] c_V_LAST   = 11'(c_V_TOTAL - 1);
    localparam logic [11:0] c_H_ACT    = 12'(H_ACTIVE);
    localparam logic [10:0] c_V_ACT    = 11'(V_ACTIVE);
    localparam logic [11:0] c_HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [14:0] c_H_ACT_15 = 15'(H_ACTIVE);
    localparam logic [19:0] c_H_ACT_20 = 20'(H_ACTIVE);

    logic [11:0] r_h;
    logic [10:0] r_v;
    logic [1:0]  r_pat;

    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_first;
    logic        w_hblank;
    logic        w_vblank;
    logic        w_hsync;
    logic        w_vsync;
    logic        w_de;
    logic [1:0]  w_pat;
    logic [14:0] w_bar_idx;
    logic [19:0] w_ramp_q;
    logic [7:0]  w_grey;
    logic [23:0] w_bar_rgb;
    logic [23:0] w_rgb;

    assign w_h_wrap = (r_h == c_H_LAST);
    assign w_v_wrap = (r_v == c_V_LAST);
    assign w_first  = (r_h == 12'd0) && (r_v == 11'd0);
    assign w_hblank = (r_h >= c_H_ACT);
    assign w_vblank = (r_v >= c_V_ACT);
    assign w_hsync  = ((r_h >= c_HS_START) && (r_h < c_HS_END)) ? HS_POL : ~HS_POL;
    // Vertical sync depends on the line count only, so it moves at h == 0.
    assign w_vsync  = ((r_v >= c_VS_START) && (r_v < c_VS_END)) ? VS_POL : ~VS_POL;
    assign w_de     = ~w_hblank & ~w_vblank;

    // The new selection already applies to pixel (0,0) so a whole frame
    // always uses a single pattern.
    assign w_pat    = w_first ? pattern_sel_i : r_pat;

    // Bar index h*8/H_ACTIVE in 15 bits: 12-bit column times 8 cannot overflow.
    assign w_bar_idx = {r_h, 3'b000} / c_H_ACT_15;
    // Ramp h*256/H_ACTIVE; saturation only guards non-active columns.
    assign w_ramp_q  = {r_h, 8'h00} / c_H_ACT_20;
    assign w_grey    = (|w_ramp_q[19:8]) ? 8'hFF : w_ramp_q[7:0];

    // Colour-bar lookup from the bar index.
    always_comb begin
        w_bar_rgb = 24'h000000;
        case (w_bar_idx)
            15'd0:   w_bar_rgb = 24'hFFFFFF;
            15'd1:   w_bar_rgb = 24'hFFFF00;
            15'd2:   w_bar_rgb = 24'h00FFFF;
            15'd3:   w_bar_rgb = 24'h00FF00;
            15'd4:   w_bar_rgb = 24'hFF00FF;
            15'd5:   w_bar_rgb = 24'hFF0000;
            15'd6:   w_bar_rgb = 24'h0000FF;
            default: w_bar_rgb = 24'h000000;
        endcase
    end

    // Pattern mux; blanked pixels are forced to black.
    always_comb begin
        w_rgb = 24'h000000;
        if (w_de) begin
            case (w_pat)
                2'd0:    w_rgb = w_bar_rgb;
                2'd1:    w_rgb = {w_grey, w_grey, w_grey};
                2'd2:    w_rgb = SOLID_RGB;
                default: w_rgb = (r_h[6] ^ r_v[6]) ? 24'hFFFFFF : 24'h000000;
            endcase
        end
    end

    // Raster position counters, stepped once per enabled pixel.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_h <= 12'd0;
            r_v <= 11'd0;
        end else if (cen_i) begin
            if (w_h_wrap) begin
                r_h <= 12'd0;
                r_v <= w_v_wrap ? 11'd0 : r_v + 11'd1;
            end else begin
                r_h <= r_h + 12'd1;
            end
        end
    end

    // Pattern selection captured only at the start of a frame.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pat <= 2'd0;
        end else if (cen_i && w_first) begin
            r_pat <= pattern_sel_i;
        end
    end

    // Output stage: every output registered from the same counter state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vid_rgb_o     <= 24'h000000;
            vh_blank_o    <= 2'b11;
            dvh_sync_o    <= {1'b0, ~VS_POL, ~HS_POL};
            frame_start_o <= 1'b0;
            h_cnt_o       <= 12'd0;
            v_cnt_o       <= 11'd0;
        end else if (cen_i) begin
            vid_rgb_o     <= w_rgb;
            vh_blank_o    <= {w_vblank, w_hblank};
            dvh_sync_o    <= {w_de, w_vsync, w_hsync};
            frame_start_o <= w_first;
            h_cnt_o       <= r_h;
            v_cnt_o       <= r_v;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module  : tb_video_timing_gen
// Brief   : Self-checking bench for video_timing_gen. A reduced-raster
//           instance runs whole frames; a default 1080p instance checks the
//           first lines against the full-size timing.
// Revision: 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    localparam int S_HA = 136, S_HF = 6, S_HS = 5, S_HB = 9;
    localparam int S_VA = 70,  S_VF = 2, S_VS = 3, S_VB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        cen   = 1'b0;
    logic [1:0]  sel   = 2'd0;

    logic [23:0] s_rgb, d_rgb;
    logic [1:0]  s_blank, d_blank;
    logic [2:0]  s_sync, d_sync;
    logic        s_fs, d_fs;
    logic [11:0] s_h, d_h;
    logic [10:0] s_v, d_v;

    video_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .cen_i(cen), .pattern_sel_i(sel),
        .vid_rgb_o(s_rgb), .vh_blank_o(s_blank), .dvh_sync_o(s_sync),
        .frame_start_o(s_fs), .h_cnt_o(s_h), .v_cnt_o(s_v)
    );

    video_timing_gen dut_d (
        .clk_i(clk), .rst_ni(rst_n), .cen_i(cen), .pattern_sel_i(sel),
        .vid_rgb_o(d_rgb), .vh_blank_o(d_blank), .dvh_sync_o(d_sync),
        .frame_start_o(d_fs), .h_cnt_o(d_h), .v_cnt_o(d_v)
    );

    typedef struct packed {
        logic [23:0] rgb;
        logic [1:0]  blank;
        logic [2:0]  sync;
        logic        fs;
        logic [11:0] h;
        logic [10:0] v;
    } out_t;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
    } tim_t;

    typedef struct {
        int          inst;
        int          sel;
        int          fpat;
        int          h;
        int          v;
        logic [23:0] rgb;
        logic [1:0]  blank;
        logic [2:0]  sync;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    tim_t T[2];
    int   mn[2];
    int   mpat[2];
    int   opat[2];
    out_t ex[2];
    int   gap = 0;
    bit   fs_seen = 1'b0;
    vec_t vecs[$];

    function automatic int flen(tim_t t);
        return (t.ha + t.hf + t.hs + t.hb) * (t.va + t.vf + t.vs + t.vb);
    endfunction

    function automatic logic [23:0] bar_col(int i);
        case (i)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Expected output for pixel number n of a frame (both polarities active-high).
    function automatic out_t pix(tim_t t, int n, int pat);
        out_t o;
        int   ht, h, v, g;
        bit   hb, vb, hs, vs;
        ht = t.ha + t.hf + t.hs + t.hb;
        h  = n % ht;
        v  = n / ht;
        hb = (h >= t.ha);
        vb = (v >= t.va);
        hs = (h >= t.ha + t.hf) && (h < t.ha + t.hf + t.hs);
        vs = (v >= t.va + t.vf) && (v < t.va + t.vf + t.vs);
        o.h     = 12'(h);
        o.v     = 11'(v);
        o.fs    = (n == 0);
        o.blank = {vb, hb};
        o.sync  = {~hb & ~vb, vs, hs};
        o.rgb   = 24'h0;
        if (!hb && !vb) begin
            case (pat)
                0: o.rgb = bar_col((h * 8) / t.ha);
                1: begin
                    g = (h * 256) / t.ha;
                    o.rgb = {8'(g), 8'(g), 8'(g)};
                end
                2: o.rgb = 24'hFF5A43;
                default: o.rgb = ((((h / 64) ^ (v / 64)) % 2) == 1) ? 24'hFFFFFF : 24'h0;
            endcase
        end
        return o;
    endfunction

    function automatic out_t act(int i);
        if (i == 0) return {s_rgb, s_blank, s_sync, s_fs, s_h, s_v};
        return {d_rgb, d_blank, d_sync, d_fs, d_h, d_v};
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    // One clock: update the reference at the edge, compare at the falling edge.
    task automatic step();
        int p;
        bit en;
        en = rst_n && cen;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mn[i]       = 0;
                mpat[i]     = 0;
                opat[i]     = 0;
                ex[i]       = '0;
                ex[i].blank = 2'b11;
            end else if (cen) begin
                p       = (mn[i] == 0) ? int'(sel) : mpat[i];
                mpat[i] = p;
                opat[i] = p;
                ex[i]   = pix(T[i], mn[i], p);
                mn[i]   = (mn[i] + 1) % flen(T[i]);
            end
        end
        @(negedge clk);
        check("out_small", act(0), ex[0]);
        check("out_1080p", act(1), ex[1]);
        if (!rst_n) begin
            fs_seen = 1'b0;
        end else if (en) begin
            gap++;
            if (s_fs) begin
                if (fs_seen) check("fs_period", gap, flen(T[0]));
                fs_seen = 1'b1;
                gap     = 0;
            end
        end
    endtask

    task automatic add(int inst, int s, int fp, int h, int v,
                       logic [23:0] rgb, logic [1:0] bl, logic [2:0] sy);
        vec_t r;
        r.inst = inst; r.sel = s; r.fpat = fp; r.h = h; r.v = v;
        r.rgb = rgb; r.blank = bl; r.sync = sy;
        vecs.push_back(r);
    endtask

    // Run until the chosen instance shows (h,v) under the wanted frame pattern.
    task automatic run_vec(int k);
        vec_t r;
        out_t a;
        bit   found;
        r     = vecs[k];
        sel   = 2'(r.sel);
        cen   = 1'b1;
        rst_n = 1'b1;
        found = 1'b0;
        a     = '0;
        for (int n = 0; n < 3 * flen(T[0]) && !found; n++) begin
            step();
            a = act(r.inst);
            if (a.h == 12'(r.h) && a.v == 11'(r.v) && opat[r.inst] == r.fpat) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL vec%0d timeout waiting for (%0d,%0d)", k, r.h, r.v);
        end else begin
            check($sformatf("vec%0d(%0d,%0d)", k, r.h, r.v),
                  {35'd0, a.rgb, a.blank, a.sync}, {35'd0, r.rgb, r.blank, r.sync});
        end
    endtask

    initial begin
        bit found;
        T[0] = '{S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB};
        T[1] = '{1920, 88, 44, 148, 1080, 4, 5, 36};

        // 1080p first line
        add(1, 0, 0,  240, 0, 24'hFFFF00, 2'b00, 3'b100);
        add(1, 0, 0, 1919, 0, 24'h000000, 2'b00, 3'b100);
        add(1, 0, 0, 1920, 0, 24'h000000, 2'b01, 3'b000);
        add(1, 0, 0, 2007, 0, 24'h000000, 2'b01, 3'b000);
        add(1, 0, 0, 2008, 0, 24'h000000, 2'b01, 3'b001);
        add(1, 0, 0, 2051, 0, 24'h000000, 2'b01, 3'b001);
        add(1, 0, 0, 2052, 0, 24'h000000, 2'b01, 3'b000);
        add(1, 0, 0, 2199, 0, 24'h000000, 2'b01, 3'b000);
        add(1, 0, 0,    0, 1, 24'hFFFFFF, 2'b00, 3'b100);
        // reduced raster, bars
        add(0, 0, 0,   0, 20, 24'hFFFFFF, 2'b00, 3'b100);
        add(0, 0, 0,  16, 20, 24'hFFFFFF, 2'b00, 3'b100);
        add(0, 0, 0,  17, 20, 24'hFFFF00, 2'b00, 3'b100);
        add(0, 0, 0,  34, 20, 24'h00FFFF, 2'b00, 3'b100);
        add(0, 0, 0, 135, 20, 24'h000000, 2'b00, 3'b100);
        add(0, 0, 0, 136, 20, 24'h000000, 2'b01, 3'b000);
        add(0, 0, 0, 141, 20, 24'h000000, 2'b01, 3'b000);
        add(0, 0, 0, 142, 20, 24'h000000, 2'b01, 3'b001);
        add(0, 0, 0, 146, 20, 24'h000000, 2'b01, 3'b001);
        add(0, 0, 0, 147, 20, 24'h000000, 2'b01, 3'b000);
        // solid selected mid-frame: rest of this frame stays bars
        add(0, 2, 0,  10, 40, 24'hFFFFFF, 2'b00, 3'b100);
        add(0, 2, 0, 135, 69, 24'h000000, 2'b00, 3'b100);
        add(0, 2, 0,   0, 70, 24'h000000, 2'b10, 3'b000);
        add(0, 2, 0,   0, 72, 24'h000000, 2'b10, 3'b010);
        add(0, 2, 0, 142, 72, 24'h000000, 2'b11, 3'b011);
        add(0, 2, 0, 155, 74, 24'h000000, 2'b11, 3'b010);
        add(0, 2, 0,   0, 75, 24'h000000, 2'b10, 3'b000);
        add(0, 2, 2,   5,  5, 24'hFF5A43, 2'b00, 3'b100);
        add(0, 2, 2, 140,  5, 24'h000000, 2'b01, 3'b000);
        add(0, 2, 2, 100, 69, 24'hFF5A43, 2'b00, 3'b100);
        // checkerboard
        add(0, 3, 3,   0,  0, 24'h000000, 2'b00, 3'b100);
        add(0, 3, 3,  63,  0, 24'h000000, 2'b00, 3'b100);
        add(0, 3, 3,  64,  0, 24'hFFFFFF, 2'b00, 3'b100);
        add(0, 3, 3,   0, 64, 24'hFFFFFF, 2'b00, 3'b100);
        add(0, 3, 3,  64, 64, 24'h000000, 2'b00, 3'b100);
        add(0, 3, 3, 135, 69, 24'hFFFFFF, 2'b00, 3'b100);
        // grey ramp
        add(0, 1, 1,   0,  3, 24'h000000, 2'b00, 3'b100);
        add(0, 1, 1,   1,  3, 24'h010101, 2'b00, 3'b100);
        add(0, 1, 1,  68,  3, 24'h808080, 2'b00, 3'b100);
        add(0, 1, 1, 135,  3, 24'hFEFEFE, 2'b00, 3'b100);
        add(0, 1, 1, 140,  3, 24'h000000, 2'b01, 3'b000);

        // Reset held with the clock enable high
        rst_n = 1'b0; cen = 1'b1; sel = 2'd0;
        repeat (3) step();
        check("reset_small", act(0), {24'h0, 2'b11, 3'b000, 1'b0, 12'd0, 11'd0});
        check("reset_1080p", act(1), {24'h0, 2'b11, 3'b000, 1'b0, 12'd0, 11'd0});

        // First enabled cycle presents pixel (0,0)
        rst_n = 1'b1;
        step();
        check("first_small", act(0), {24'hFFFFFF, 2'b00, 3'b100, 1'b1, 12'd0, 11'd0});
        check("first_1080p", act(1), {24'hFFFFFF, 2'b00, 3'b100, 1'b1, 12'd0, 11'd0});

        for (int k = 0; k < vecs.size(); k++) run_vec(k);

        // Gappy clock enable with occasional pattern changes
        for (int n = 0; n < 16000; n++) begin
            cen = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) sel = 2'($urandom);
            step();
        end

        // Reset in the middle of a line while the enable is low
        cen = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 2 * flen(T[0]) && !found; n++) begin
            step();
            if (s_h == 12'd100 && s_v == 11'd30) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL midline_wait timeout");
        end
        cen = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        check("midrst_small", act(0), {24'h0, 2'b11, 3'b000, 1'b0, 12'd0, 11'd0});
        check("midrst_1080p", act(1), {24'h0, 2'b11, 3'b000, 1'b0, 12'd0, 11'd0});
        rst_n = 1'b1; cen = 1'b1; sel = 2'd3;
        step();
        check("restart_small", act(0), {24'h000000, 2'b00, 3'b100, 1'b1, 12'd0, 11'd0});
        check("restart_1080p", act(1), {24'h000000, 2'b00, 3'b100, 1'b1, 12'd0, 11'd0});
        repeat (300) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Upstream video source for the video processing stage.
- Generates raster timing (blank flags, H/V sync, data-enable) plus a selectable test pattern.
- Its outputs connect directly to that stage's vid_rgb_i, vh_blank_i and dvh_sync_i inputs.
- Defaults give CEA-861 1080p60 timing; the block advances only on video clock-enable cycles.

Parameters:
H_ACTIVE, 1920, active pixels per line
H_FP, 88, horizontal front porch (pixels)
H_SYNC, 44, hsync width (pixels)
H_BP, 148, horizontal back porch (pixels)
V_ACTIVE, 1080, active lines per frame
V_FP, 4, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 36, vertical back porch (lines)
HS_POL, 1, hsync active level
VS_POL, 1, vsync active level
SOLID_RGB, 24'hFF_5A_43, colour for solid pattern

Ports:
clk_i  in  1  pixel clock
rst_ni  in  1  synchronous reset, active-low
cen_i  in  1  video clock enable; all state advances only when high
pattern_sel_i  in  2  0 bars, 1 grey ramp, 2 solid, 3 checkerboard
vid_rgb_o  out  24  R[23:16] G[15:8] B[7:0]
vh_blank_o  out  2  {Vblank, Hblank}
dvh_sync_o  out  3  {D_sync(data enable), Vsync, Hsync}
frame_start_o  out  1  high for the enabled cycle carrying pixel (0,0)
h_cnt_o  out  12  current output pixel column
v_cnt_o  out  11  current output line

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Internal counters h, v:
  - Reset to 0.
  - On cen_i: h increments; at H_TOTAL-1, h wraps to 0 and v increments.
  - v wraps to 0 when h and v both wrap.
- When cen_i is low, every register, including the outputs, holds.
- Reset:
  - Taken when rst_ni=0 at a clk_i edge, regardless of cen_i.
  - Reset output values: vid_rgb_o=0, vh_blank_o=2'b11, dvh_sync_o={0,~VS_POL,~HS_POL}, frame_start_o=0, h_cnt_o=0, v_cnt_o=0.
  - Pattern register resets to 0 (bars).
- Latency: outputs are registered from the counter state. On the first cen_i after reset release, the outputs present pixel (0,0) and the counters move to (1,0). All outputs stay mutually aligned at all times.
- Flag decode, per counter state (h,v):
  - hblank = h >= H_ACTIVE
  - vblank = v >= V_ACTIVE
  - hsync active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vsync active when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; it changes only at line boundaries (h=0)
  - sync output level = POL when active, ~POL otherwise
  - D_sync = ~hblank & ~vblank
- frame_start_o = (h==0 && v==0), registered with the other outputs.
- Pattern select:
  - pattern_sel_i is sampled into the pattern register only on the enabled cycle where h==0 && v==0.
  - Mid-frame changes never tear the image.
- Colour, computed when D_sync=1; otherwise vid_rgb_o=0:
  - Bars: bar index = h*8/H_ACTIVE, integer, range 0..7.
    - Colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
    - Multiplication must be 15-bit wide, no overflow.
  - Ramp: R=G=B = (h*256/H_ACTIVE)[7:0]; 0 at h=0, 255 at h=H_ACTIVE-1 for the default, monotonic non-decreasing.
  - Solid: SOLID_RGB.
  - Checkerboard: white if h[6]^v[6]=1, else black.
- h_cnt_o and v_cnt_o give the pixel position on the outputs, not the internal counters.

Test Plan:
- Reset with cen_i=1 then release.
  - Expect first enabled output frame_start_o=1, vh_blank_o=00, dvh_sync_o=3'b100, h_cnt_o=0, v_cnt_o=0.
  - Expect frame_start_o to recur exactly every 2200*1125=2475000 enabled cycles.
- Defaults, one line.
  - Hblank rises at h=1920.
  - Hsync high for h=2008..2051 (44 cycles).
  - D_sync low for h=1920..2199.
  - Vsync high for lines 1084..1088, transitions coincident with h_cnt_o=0.
- cen_i toggled 1-0-1 pseudo-randomly → output sequence identical to the cen_i=1 run, with outputs held while cen_i=0.
- pattern_sel_i=0, then 2 mid-frame at v=500.
  - Expect line 0..1079 of the current frame as bars: h=0 FFFFFF, h=240 FFFF00, h=1919 000000.
  - Expect the next frame entirely FF5A43; blank pixels 0.
- pattern_sel_i=3.
  - Expect (h=0,v=0) black, (64,0) white, (64,64) black.
  - pattern_sel_i=1 → ramp: (0,*)=000000, (1919,*)=FFFFFF.
- rst_ni asserted mid-line (h=1000, v=300) with cen_i=0 → reset values on the next clk_i edge; output restarts at pixel (0,0).
